// File: rtl/sc_spi_bufctl_if.sv
// Bus bundle for sc_spi_bufctl: the host buffer/control port plus the link
// to the SPI protocol controller. The slave modport is the buffer block's
// view; the master modport is the view of whatever drives it (host and
// controller together).
// Optional IRQ/IRQCLR pair exists only when SC_SPI_BUF_IRQ_EN is defined.
interface sc_spi_bufctl_if;
  // Host side
  logic        TXWE;
  logic [3:0]  TXWADDR;
  logic [31:0] TXWDATA;
  logic [3:0]  RXRADDR;
  logic [31:0] RXRDATA;
  logic        XSTART;
  logic        XBUSY;
  logic        XDONE;
  logic        TXWERR;
  // Controller side
  logic        SPISTART;
  logic        SPIBUSY;
  logic [3:0]  TXDPT;
  logic [31:0] TXDATA;
  logic [31:0] RXDATA;
  logic        RXVALID;
  logic [3:0]  RXDPT;
`ifdef SC_SPI_BUF_IRQ_EN
  logic        IRQ;
  logic        IRQCLR;
`endif

  modport slave (
`ifdef SC_SPI_BUF_IRQ_EN
    output IRQ,
    input  IRQCLR,
`endif
    input  TXWE,
    input  TXWADDR,
    input  TXWDATA,
    input  RXRADDR,
    output RXRDATA,
    input  XSTART,
    output XBUSY,
    output XDONE,
    output TXWERR,
    output SPISTART,
    input  SPIBUSY,
    input  TXDPT,
    output TXDATA,
    input  RXDATA,
    input  RXVALID,
    input  RXDPT
  );

  modport master (
`ifdef SC_SPI_BUF_IRQ_EN
    input  IRQ,
    output IRQCLR,
`endif
    output TXWE,
    output TXWADDR,
    output TXWDATA,
    output RXRADDR,
    input  RXRDATA,
    output XSTART,
    input  XBUSY,
    input  XDONE,
    input  TXWERR,
    input  SPISTART,
    output SPIBUSY,
    output TXDPT,
    input  TXDATA,
    output RXDATA,
    output RXVALID,
    output RXDPT
  );
endinterface

// File: rtl/sc_spi_bufctl.sv
// sc_spi_bufctl: 16x32 TX/RX word buffers and the one-frame sequencer that
// sits upstream of the SPI protocol controller.
//  - TX buffer is host-writable only while idle; the controller reads it
//    combinationally through TXDPT.
//  - RX buffer captures RXDATA at RXDPT on every RXVALID, in any state.
//  - One XSTART runs SPISTART/SPIBUSY handshake, then waits DRAIN_CYC cycles
//    for the RX pipeline to catch up before pulsing XDONE.
// Optional feature: define SC_SPI_BUF_IRQ_EN to add a sticky IRQ output with
// an IRQCLR clear input.
module sc_spi_bufctl #(
  // Cycles to wait after SPIBUSY falls, legal range 1..7
  parameter int unsigned DRAIN_CYC = 3
) (
  input logic            SPICLK,
  input logic            SYSRSTB,
  sc_spi_bufctl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam logic [2:0] DrainLoad = 3'(DRAIN_CYC - 1);

  state_e      state_q;
  logic [2:0]  drain_cnt_q;
  logic        spistart_q;
  logic        xbusy_q;
  logic        xdone_q;
  logic        txwerr_q;
  logic [31:0] txbuf_q [16];
  logic [31:0] rxbuf_q [16];
  logic [31:0] rxrdata_q;
`ifdef SC_SPI_BUF_IRQ_EN
  logic        irq_q;
`endif

  // Sequencer: state, drain counter and all registered status outputs.
  always_ff @(posedge SPICLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      state_q     <= StIdle;
      drain_cnt_q <= 3'd0;
      spistart_q  <= 1'b0;
      xbusy_q     <= 1'b0;
      xdone_q     <= 1'b0;
      txwerr_q    <= 1'b0;
`ifdef SC_SPI_BUF_IRQ_EN
      irq_q       <= 1'b0;
`endif
    end else begin
      // Start clears the error; a write attempt while busy latches it.
      if (state_q == StIdle) begin
        if (bus.XSTART) begin
          txwerr_q <= 1'b0;
        end
      end else if (bus.TXWE) begin
        txwerr_q <= 1'b1;
      end

`ifdef SC_SPI_BUF_IRQ_EN
      // Set on entry to DONE and held through it, so a coincident clear loses.
      if ((state_q == StDrain && drain_cnt_q == 3'd0) || state_q == StDone) begin
        irq_q <= 1'b1;
      end else if (bus.IRQCLR) begin
        irq_q <= 1'b0;
      end
`endif

      unique case (state_q)
        StIdle: begin
          if (bus.XSTART) begin
            state_q    <= StReq;
            spistart_q <= 1'b1;
            xbusy_q    <= 1'b1;
          end
        end
        StReq: begin
          // No timeout: wait as long as the controller takes to respond.
          if (bus.SPIBUSY) begin
            state_q    <= StRun;
            spistart_q <= 1'b0;
          end
        end
        StRun: begin
          if (!bus.SPIBUSY) begin
            state_q     <= StDrain;
            drain_cnt_q <= DrainLoad;
          end
        end
        StDrain: begin
          if (drain_cnt_q == 3'd0) begin
            state_q <= StDone;
            xdone_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q - 3'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          xdone_q <= 1'b0;
          xbusy_q <= 1'b0;
        end
        default: begin
          state_q    <= StIdle;
          spistart_q <= 1'b0;
          xbusy_q    <= 1'b0;
          xdone_q    <= 1'b0;
        end
      endcase
    end
  end

  // TX buffer: host writes land only while idle (including the XSTART cycle).
  always_ff @(posedge SPICLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      for (int i = 0; i < 16; i++) begin
        txbuf_q[i] <= 32'd0;
      end
    end else if (bus.TXWE && state_q == StIdle) begin
      txbuf_q[bus.TXWADDR] <= bus.TXWDATA;
    end
  end

  // RX buffer capture and registered host read port; same-address
  // read/write on one edge returns the pre-write word.
  always_ff @(posedge SPICLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      for (int i = 0; i < 16; i++) begin
        rxbuf_q[i] <= 32'd0;
      end
      rxrdata_q <= 32'd0;
    end else begin
      if (bus.RXVALID) begin
        rxbuf_q[bus.RXDPT] <= bus.RXDATA;
      end
      rxrdata_q <= rxbuf_q[bus.RXRADDR];
    end
  end

  assign bus.TXDATA   = txbuf_q[bus.TXDPT];
  assign bus.RXRDATA  = rxrdata_q;
  assign bus.XBUSY    = xbusy_q;
  assign bus.XDONE    = xdone_q;
  assign bus.TXWERR   = txwerr_q;
  assign bus.SPISTART = spistart_q;
`ifdef SC_SPI_BUF_IRQ_EN
  assign bus.IRQ      = irq_q;
`endif

endmodule

// File: tb/tb_sc_spi_bufctl.sv
// Bench for sc_spi_bufctl: directed stimulus, a timestamp-based reference
// model checked every cycle, and literal expectations at key points.
module tb_sc_spi_bufctl;

  localparam int DRAIN_CYC = 3;

  logic SPICLK  = 1'b0;
  logic SYSRSTB = 1'b1;

  sc_spi_bufctl_if bus ();

  sc_spi_bufctl #(.DRAIN_CYC(DRAIN_CYC)) dut (
    .SPICLK (SPICLK),
    .SYSRSTB(SYSRSTB),
    .bus    (bus)
  );

  always #5 SPICLK = ~SPICLK;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: buffers as plain arrays, transfer phase as timestamps.
  logic [31:0] m_tx [16];
  logic [31:0] m_rx [16];
  logic [31:0] m_rxr;
  bit          m_act, m_seen, m_fallen, m_werr, m_irq;
  int          m_fall_edge;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge SPICLK);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge SPICLK or negedge SYSRSTB);
      if (!SYSRSTB) begin
        for (int i = 0; i < 16; i++) begin
          m_tx[i] = 32'd0;
          m_rx[i] = 32'd0;
        end
        m_rxr = 32'd0;
        m_act = 0; m_seen = 0; m_fallen = 0; m_werr = 0; m_irq = 0;
        m_fall_edge = 0;
      end else begin
        bit done_now, end_now;
        cyc++;
        done_now = m_act && m_fallen && (cyc == m_fall_edge + DRAIN_CYC);
        end_now  = m_act && m_fallen && (cyc == m_fall_edge + DRAIN_CYC + 1);
        m_rxr = m_rx[bus.RXRADDR];
        if (bus.RXVALID) m_rx[bus.RXDPT] = bus.RXDATA;
        if (bus.TXWE) begin
          if (!m_act) m_tx[bus.TXWADDR] = bus.TXWDATA;
          else m_werr = 1;
        end
        if (!m_act && bus.XSTART) begin
          m_act = 1; m_seen = 0; m_fallen = 0; m_werr = 0;
        end else if (m_act && !m_seen) begin
          if (bus.SPIBUSY) m_seen = 1;
        end else if (m_act && !m_fallen) begin
          if (!bus.SPIBUSY) begin
            m_fallen = 1;
            m_fall_edge = cyc;
          end
        end
        if (end_now) m_act = 0;
`ifdef SC_SPI_BUF_IRQ_EN
        if (done_now || end_now) m_irq = 1;
        else if (bus.IRQCLR) m_irq = 0;
`endif
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge SPICLK);
      chk("xbusy",    {31'd0, bus.XBUSY},    {31'd0, m_act});
      chk("spistart", {31'd0, bus.SPISTART}, {31'd0, m_act && !m_seen});
      chk("xdone",    {31'd0, bus.XDONE},
          {31'd0, m_act && m_fallen && (cyc == m_fall_edge + DRAIN_CYC)});
      chk("txwerr",   {31'd0, bus.TXWERR},   {31'd0, m_werr});
      chk("txdata",   bus.TXDATA,  m_tx[bus.TXDPT]);
      chk("rxrdata",  bus.RXRDATA, m_rxr);
`ifdef SC_SPI_BUF_IRQ_EN
      chk("irq",      {31'd0, bus.IRQ},      {31'd0, m_irq});
`endif
    end
  end

  task automatic wait_done(output int dcyc);
    bit got;
    got  = 0;
    dcyc = -1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge SPICLK);
      if (bus.XDONE === 1'b1) begin
        got  = 1;
        dcyc = cyc;
      end
    end
    chk("xdone_seen", {31'd0, got}, 32'd1);
    tick();
  endtask

  initial begin
    int c, d;
    bus.TXWE = 0; bus.TXWADDR = 0; bus.TXWDATA = 0; bus.RXRADDR = 0;
    bus.XSTART = 0; bus.SPIBUSY = 0; bus.TXDPT = 0; bus.RXDATA = 0;
    bus.RXVALID = 0; bus.RXDPT = 0;
`ifdef SC_SPI_BUF_IRQ_EN
    bus.IRQCLR = 0;
`endif
    #2 SYSRSTB = 1'b0;
    repeat (3) tick();
    @(negedge SPICLK);
    chk("rst_xbusy",   {31'd0, bus.XBUSY},    32'd0);
    chk("rst_rxrdata", bus.RXRDATA,           32'd0);
    tick();
    SYSRSTB = 1'b1;
    tick();

    // T1 basic transfer
    bus.TXWE = 1; bus.TXWADDR = 0; bus.TXWDATA = 32'hA5A5_1234;
    tick();
    bus.TXWE = 0; bus.TXDPT = 0;
    @(negedge SPICLK);
    chk("t1_txdata", bus.TXDATA, 32'hA5A5_1234);
    tick();
    bus.XSTART = 1;
    tick();
    bus.XSTART = 0;
    tick();
    @(negedge SPICLK);
    chk("t1_spistart_hold", {31'd0, bus.SPISTART}, 32'd1);
    tick();
    bus.SPIBUSY = 1;
    repeat (10) tick();
    bus.SPIBUSY = 0;
    c = cyc;
    wait_done(d);
    chk("t1_done_latency", 32'(d - c), 32'(DRAIN_CYC + 1));
    @(negedge SPICLK);
    chk("t1_xbusy_idle", {31'd0, bus.XBUSY}, 32'd0);
    tick();

    // T2 TX mux sweep
    for (int n = 0; n < 16; n++) begin
      bus.TXWE = 1; bus.TXWADDR = 4'(n); bus.TXWDATA = 32'h1000_0000 + 32'(n);
      tick();
    end
    bus.TXWE = 0;
    for (int n = 0; n < 16; n++) begin
      bus.TXDPT = 4'(n);
      @(negedge SPICLK);
      chk("t2_txmux", bus.TXDATA, 32'h1000_0000 + 32'(n));
      tick();
    end

    // T3 late RX capture during drain, plus read-during-write
    bus.XSTART = 1;
    tick();
    bus.XSTART = 0; bus.SPIBUSY = 1;
    repeat (3) tick();
    bus.SPIBUSY = 0;
    tick();
    tick();
    bus.RXVALID = 1; bus.RXDPT = 3; bus.RXDATA = 32'hDEAD_BEEF; bus.RXRADDR = 3;
    tick();
    bus.RXVALID = 0;
    @(negedge SPICLK);
    chk("t3_rx_old", bus.RXRDATA, 32'd0);
    tick();
    @(negedge SPICLK);
    chk("t3_rx_new", bus.RXRDATA, 32'hDEAD_BEEF);
    chk("t3_xdone",  {31'd0, bus.XDONE}, 32'd1);
    tick();
    tick();

    // T4 write while busy
    bus.XSTART = 1;
    tick();
    bus.XSTART = 0; bus.SPIBUSY = 1;
    tick();
    tick();
    bus.TXWE = 1; bus.TXWADDR = 0; bus.TXWDATA = 32'hFFFF_FFFF;
    tick();
    bus.TXWE = 0; bus.TXDPT = 0;
    @(negedge SPICLK);
    chk("t4_txwerr", {31'd0, bus.TXWERR}, 32'd1);
    chk("t4_txbuf0", bus.TXDATA, 32'h1000_0000);
    tick();
    bus.SPIBUSY = 0;
    wait_done(d);
    @(negedge SPICLK);
    chk("t4_txwerr_sticky", {31'd0, bus.TXWERR}, 32'd1);
    tick();
    bus.XSTART = 1;
    tick();
    bus.XSTART = 0;
    @(negedge SPICLK);
    chk("t4_txwerr_clr", {31'd0, bus.TXWERR}, 32'd0);
    tick();

    // T5 reset mid-transfer
    bus.SPIBUSY = 1;
    repeat (3) tick();
    SYSRSTB = 1'b0;
    @(negedge SPICLK);
    chk("t5_xbusy",    {31'd0, bus.XBUSY},    32'd0);
    chk("t5_spistart", {31'd0, bus.SPISTART}, 32'd0);
    chk("t5_txwerr",   {31'd0, bus.TXWERR},   32'd0);
    chk("t5_rxrdata",  bus.RXRDATA,           32'd0);
    tick();
    bus.SPIBUSY = 0;
    tick();
    SYSRSTB = 1'b1;
    bus.TXDPT = 5;
    for (int a = 0; a < 16; a++) begin
      bus.RXRADDR = 4'(a);
      tick();
      @(negedge SPICLK);
      chk("t5_rx_zero", bus.RXRDATA, 32'd0);
    end
    chk("t5_tx_zero", bus.TXDATA, 32'd0);
    tick();

`ifdef SC_SPI_BUF_IRQ_EN
    // T6 sticky IRQ, set beats clear
    bus.XSTART = 1;
    tick();
    bus.XSTART = 0; bus.SPIBUSY = 1;
    repeat (3) tick();
    bus.SPIBUSY = 0;
    repeat (DRAIN_CYC + 1) tick();
    bus.IRQCLR = 1;
    @(negedge SPICLK);
    chk("t6_xdone", {31'd0, bus.XDONE}, 32'd1);
    chk("t6_irq_set", {31'd0, bus.IRQ}, 32'd1);
    tick();
    bus.IRQCLR = 0;
    @(negedge SPICLK);
    chk("t6_irq_setwins", {31'd0, bus.IRQ}, 32'd1);
    tick();
    bus.IRQCLR = 1;
    tick();
    bus.IRQCLR = 0;
    @(negedge SPICLK);
    chk("t6_irq_clr", {31'd0, bus.IRQ}, 32'd0);
    tick();
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
